// File: rtl/alu_result_stage.sv
// alu_result_stage
//   Registered output stage behind the 32-bit AND/OR units and the adder/subtractor.
//   Picks the result for alu_op, derives SLT/NOR and the zero/illegal (and optionally
//   overflow) flags, and hands the result downstream over valid/ready. A main+skid
//   register pair keeps in_ready registered, so downstream stalls never reach the ALU
//   combinationally.
//
//   Optional feature macro: ALU_OVF_FLAG_EN (adds the ovf port and per-entry ovf storage).
//
// Ports
//   clk, rst_n          rising-edge clock, synchronous active-low reset
//   in_valid/in_ready   upstream handshake (in_ready registered)
//   alu_op              000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT, 100 NOR
//   and_r/or_r/add_r/sub_r, a_msb/b_msb   unit results and operand sign bits
//   out_valid/out_ready downstream handshake
//   R, zero, illegal    selected result and flags
//   ovf                 signed overflow (ALU_OVF_FLAG_EN only)
module alu_result_stage #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [2:0]   alu_op,
    input  logic [W-1:0] and_r,
    input  logic [W-1:0] or_r,
    input  logic [W-1:0] add_r,
    input  logic [W-1:0] sub_r,
    input  logic         a_msb,
    input  logic         b_msb,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] R,
    output logic         zero,
    output logic         illegal
`ifdef ALU_OVF_FLAG_EN
    ,
    output logic         ovf
`endif
);

    typedef enum logic [1:0] {
        EMPTY,
        ONE,
        TWO
    } state_t;

    state_t       state, state_nxt;

    logic [W-1:0] sel_r;
    logic         sel_zero;
    logic         sel_illegal;
    logic         ovf_sub;
    logic         accept;
    logic         emit;

    logic [W-1:0] skid_r;
    logic         skid_zero;
    logic         skid_illegal;
`ifdef ALU_OVF_FLAG_EN
    logic         ovf_add;
    logic         sel_ovf;
    logic         skid_ovf;
`endif

    // Result select and flag derivation
    always_comb begin
        ovf_sub = (a_msb != b_msb) && (sub_r[W-1] != a_msb);
`ifdef ALU_OVF_FLAG_EN
        ovf_add = (a_msb == b_msb) && (add_r[W-1] != a_msb);
        sel_ovf = 1'b0;
`endif
        sel_r       = '0;
        sel_illegal = 1'b0;
        case (alu_op)
            3'b000: sel_r = and_r;
            3'b001: sel_r = or_r;
            3'b010: begin
                sel_r = add_r;
`ifdef ALU_OVF_FLAG_EN
                sel_ovf = ovf_add;
`endif
            end
            3'b110: begin
                sel_r = sub_r;
`ifdef ALU_OVF_FLAG_EN
                sel_ovf = ovf_sub;
`endif
            end
            3'b100: sel_r = ~or_r;
            // Sign of A-B is wrong exactly when the subtraction overflowed
            3'b111: sel_r = {{(W-1){1'b0}}, sub_r[W-1] ^ ovf_sub};
            default: sel_illegal = 1'b1;
        endcase
        sel_zero = (sel_r == '0);
    end

    // Buffer occupancy
    always_comb begin
        accept    = in_valid && in_ready;
        emit      = out_valid && out_ready;
        state_nxt = state;
        case (state)
            EMPTY: if (accept) state_nxt = ONE;
            ONE: begin
                if (accept && !emit)      state_nxt = TWO;
                else if (!accept && emit) state_nxt = EMPTY;
            end
            TWO: if (emit) state_nxt = ONE;
            default: state_nxt = EMPTY;
        endcase
    end

    // Main entry drives the outputs directly; skid only holds the second beat
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= EMPTY;
            in_ready     <= 1'b1;
            out_valid    <= 1'b0;
            R            <= '0;
            zero         <= 1'b1;
            illegal      <= 1'b0;
            skid_r       <= '0;
            skid_zero    <= 1'b1;
            skid_illegal <= 1'b0;
`ifdef ALU_OVF_FLAG_EN
            ovf          <= 1'b0;
            skid_ovf     <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            in_ready  <= (state_nxt != TWO);
            out_valid <= (state_nxt != EMPTY);

            if (state == TWO) begin
                if (emit) begin
                    R       <= skid_r;
                    zero    <= skid_zero;
                    illegal <= skid_illegal;
`ifdef ALU_OVF_FLAG_EN
                    ovf     <= skid_ovf;
`endif
                end
            end else if (accept && (state == EMPTY || emit)) begin
                R       <= sel_r;
                zero    <= sel_zero;
                illegal <= sel_illegal;
`ifdef ALU_OVF_FLAG_EN
                ovf     <= sel_ovf;
`endif
            end

            if (state == ONE && accept && !emit) begin
                skid_r       <= sel_r;
                skid_zero    <= sel_zero;
                skid_illegal <= sel_illegal;
`ifdef ALU_OVF_FLAG_EN
                skid_ovf     <= sel_ovf;
`endif
            end
        end
    end

endmodule

// File: tb/tb_alu_result_stage.sv
// Self-checking bench for alu_result_stage: operand-level reference model with a
// FIFO of expected results, a per-cycle compare process, and literal spot checks.
module tb_alu_result_stage;

    localparam int     W    = 32;
    localparam longint MAXS = 64'sd2147483647;
    localparam longint MINS = -64'sd2147483648;

    typedef struct packed {
        logic [W-1:0] r;
        logic         zero;
        logic         ill;
        logic         ovf;
    } ent_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   alu_op;
    logic [W-1:0] and_r, or_r, add_r, sub_r;
    logic         a_msb, b_msb;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] R;
    logic         zero;
    logic         illegal;
`ifdef ALU_OVF_FLAG_EN
    logic         ovf;
`endif

    logic [W-1:0] cur_a, cur_b;
    int           n_vec = 0;
    int           n_err = 0;
    ent_t         q[$];
    bit           armed = 1'b0;
    bit           show_reset = 1'b0;

    alu_result_stage #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_op    (alu_op),
        .and_r     (and_r),
        .or_r      (or_r),
        .add_r     (add_r),
        .sub_r     (sub_r),
        .a_msb     (a_msb),
        .b_msb     (b_msb),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .R         (R),
        .zero      (zero),
        .illegal   (illegal)
`ifdef ALU_OVF_FLAG_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Result computed from the operands themselves, using signed integer arithmetic
    function automatic ent_t ref_result(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        ent_t   e;
        longint sa, sb, s, d;
        sa    = longint'($signed(a));
        sb    = longint'($signed(b));
        s     = sa + sb;
        d     = sa - sb;
        e.r   = '0;
        e.ill = 1'b0;
        e.ovf = 1'b0;
        case (op)
            3'd0: e.r = a & b;
            3'd1: e.r = a | b;
            3'd2: begin e.r = a + b; e.ovf = (s > MAXS) || (s < MINS); end
            3'd6: begin e.r = a - b; e.ovf = (d > MAXS) || (d < MINS); end
            3'd4: e.r = ~(a | b);
            3'd7: e.r = (sa < sb) ? 1 : 0;
            default: e.ill = 1'b1;
        endcase
        e.zero = (e.r == 0);
        return e;
    endfunction

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'hFFFF_FFFF;
            3: return 32'h7FFF_FFFF;
            4: return 32'h8000_0000;
            default: return $urandom();
        endcase
    endfunction

    task automatic drive(input logic v, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        in_valid = v;
        alu_op   = op;
        cur_a    = a;
        cur_b    = b;
        and_r    = a & b;
        or_r     = a | b;
        add_r    = a + b;
        sub_r    = a - b;
        a_msb    = a[W-1];
        b_msb    = b[W-1];
    endtask

    // Reference model: FIFO of at most two pending results
    always @(posedge clk) begin : model
        bit acc, emi;
        if (!rst_n) begin
            q.delete();
            armed      <= 1'b1;
            show_reset <= 1'b1;
        end else begin
            acc = in_valid && (q.size() < 2);
            emi = out_ready && (q.size() > 0);
            if (emi) void'(q.pop_front());
            if (acc) begin
                q.push_back(ref_result(alu_op, cur_a, cur_b));
                show_reset <= 1'b0;
            end
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (armed) begin
            check("out_valid", out_valid, q.size() != 0);
            check("in_ready", in_ready, q.size() < 2);
            if (q.size() != 0) begin
                check("R", R, q[0].r);
                check("zero", zero, q[0].zero);
                check("illegal", illegal, q[0].ill);
`ifdef ALU_OVF_FLAG_EN
                check("ovf", ovf, q[0].ovf);
`endif
            end else if (show_reset) begin
                check("R_rst", R, 0);
                check("zero_rst", zero, 1);
                check("illegal_rst", illegal, 0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send_one(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [W-1:0] exp_r, input logic ez, input logic ei, input logic eo);
        drive(1'b1, op, a, b);
        tick();
        drive(1'b0, op, a, b);
        @(negedge clk);
        check("lit_valid", out_valid, 1);
        check("lit_R", R, exp_r);
        check("lit_zero", zero, ez);
        check("lit_illegal", illegal, ei);
`ifdef ALU_OVF_FLAG_EN
        check("lit_ovf", ovf, eo);
`else
        if (eo === 1'bx) $display("unexpected X in ovf expectation");
`endif
        tick();
    endtask

    task automatic check_reset_lits();
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_R", R, 0);
        check("rst_zero", zero, 1);
        check("rst_illegal", illegal, 0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int vcnt;
        vcnt = 0;

        // Reset held with in_valid asserted
        rst_n     = 1'b0;
        out_ready = 1'b1;
        drive(1'b1, 3'b010, 32'h5, 32'h7);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_lits();
        tick();
        rst_n = 1'b1;

        // Directed single transfers
        send_one(3'b000, 32'h0000_F0F0, 32'hFFFF_FFFF, 32'h0000_F0F0, 1'b0, 1'b0, 1'b0);
        send_one(3'b000, 32'h0000_F0F0, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 1'b0);
        send_one(3'b111, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
        send_one(3'b111, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 1'b0);
        send_one(3'b010, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b0, 1'b1);
        send_one(3'b110, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b1);
        send_one(3'b100, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
        send_one(3'b101, 32'h1234_5678, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b1, 1'b0);

        // Backpressure: three beats into a stalled stage
        out_ready = 1'b0;
        drive(1'b1, 3'b000, 32'h11, 32'h11);
        tick();
        drive(1'b1, 3'b000, 32'h22, 32'h22);
        tick();
        drive(1'b1, 3'b000, 32'h33, 32'h33);
        @(negedge clk);
        check("bp_in_ready", in_ready, 0);
        check("bp_head", R, 32'h11);
        tick();
        tick();
        out_ready = 1'b1;
        tick();
        @(negedge clk);
        check("bp_second", R, 32'h22);
        tick();
        drive(1'b0, 3'b000, 32'h0, 32'h0);
        @(negedge clk);
        check("bp_third", R, 32'h33);
        check("bp_third_valid", out_valid, 1);
        tick();
        tick();

        // Full throughput, then reset mid-stream
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 3'($urandom_range(0, 7)), pick(), pick());
            @(posedge clk);
            @(negedge clk);
            if (out_valid === 1'b1) vcnt++;
        end
        check("thru_count", vcnt, 16);
        rst_n = 1'b0;
        drive(1'b1, 3'b001, 32'hA5A5_0000, 32'h0000_5A5A);
        @(posedge clk);
        @(negedge clk);
        check_reset_lits();
        rst_n = 1'b1;

        // Randomized traffic with occasional resets
        for (int i = 0; i < 500; i++) begin
            rst_n     = ($urandom_range(0, 99) != 0);
            out_ready = ($urandom_range(0, 9) < 6);
            drive($urandom_range(0, 9) < 7, 3'($urandom_range(0, 7)), pick(), pick());
            tick();
        end

        rst_n     = 1'b1;
        out_ready = 1'b1;
        drive(1'b0, 3'b000, 32'h0, 32'h0);
        repeat (4) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
